// File: rtl/apb_master_pkg.sv
// Shared types and defaults for the APB master: FSM state encoding,
// default bus widths and the completion-response record.
package apb_master_pkg;

  localparam int APB_ADDR_W_DEF = 3;
  localparam int APB_DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  typedef struct packed {
    logic [APB_DATA_W_DEF-1:0] rdata;
    logic                      timeout;
  } rsp_t;

endpackage

// File: rtl/apb_master_if.sv
// Command, APB bus and response signals of the APB master bundled together;
// 'master' is the view taken by apb_master, 'slave' the view of its peers.
interface apb_master_if
  import apb_master_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W_DEF,
  parameter int DATA_W = APB_DATA_W_DEF
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_timeout;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
    output cmd_ready, psel, penable, pwrite, paddr, pwdata,
           rsp_valid, rsp_rdata, rsp_timeout
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
    input  cmd_ready, psel, penable, pwrite, paddr, pwdata,
           rsp_valid, rsp_rdata, rsp_timeout
  );

endinterface

// File: rtl/apb_master_wdog.sv
// ACCESS-phase watchdog: counts stalled cycles while en_i is high and flags
// expiry on the TIMEOUT_CYCLES-th one; clr_i restarts the count.
module apb_master_wdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired_o = en_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Holds at the expiry value; the FSM leaves ACCESS on that cycle anyway.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: command handshake in, APB SETUP/ACCESS out,
// one-cycle response pulse. Optional watchdog under APB_MASTER_TIMEOUT_EN.
module apb_master
  import apb_master_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W_DEF,
  parameter int DATA_W         = APB_DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic         clk_i,
  input  logic         reset_n,
  apb_master_if.master bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  logic cmd_ready;
  logic accept;
  logic done;
  logic abort;
  logic wd_clr;
  logic wd_en;
  logic wd_expired;

  assign wd_en  = (state_q == ACCESS) && !bus.pready;
  assign wd_clr = (state_d == SETUP);

`ifdef APB_MASTER_TIMEOUT_EN
  apb_master_wdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk_i     (clk_i),
    .reset_n   (reset_n),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .expired_o (wd_expired)
  );
`else
  logic unused_wdog;
  assign unused_wdog = wd_clr ^ wd_en ^ (TIMEOUT_CYCLES == 0);
  assign wd_expired  = 1'b0;
`endif

  assign accept = bus.cmd_valid && cmd_ready;

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) state_d = SETUP;
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // pready on the expiry cycle still counts as a normal completion.
        if (bus.pready) begin
          cmd_ready = 1'b1;
          done      = 1'b1;
          state_d   = bus.cmd_valid ? SETUP : IDLE;
        end else if (wd_expired) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    if (accept) begin
      paddr_d  = bus.cmd_addr;
      pwrite_d = bus.cmd_write;
      pwdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
    end
    rsp_valid_d   = done || abort;
    rsp_timeout_d = abort;
    rsp_rdata_d   = (done && !pwrite_q) ? bus.prdata : '0;
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.psel        = (state_q != IDLE);
  assign bus.penable     = (state_q == ACCESS);
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: the bench plays the APB responder
// (slave_mem) and predicts read data from a command-side memory (ref_mem).
module tb_apb_master;
  import apb_master_pkg::*;

  localparam int AW = 3;
  localparam int DW = 8;
  localparam int TO = 16;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   errors  = 0;
  int   checks  = 0;

  logic [DW-1:0] ref_mem   [8];
  logic [DW-1:0] slave_mem [8];

  apb_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_master #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i   (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  // One complete transfer with `waits` stalled ACCESS cycles.
  task automatic xfer(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int waits, input string tag);
    rsp_t          exp;
    logic [DW-1:0] exp_pwdata;
    exp_pwdata    = w ? d : '0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL %s idle_ready got=%b exp=1", tag, bus.cmd_ready);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = AW'($urandom);
    bus.cmd_wdata = DW'($urandom);
    #1;
    checks++;
    if ({bus.psel, bus.penable, bus.cmd_ready, bus.rsp_valid} !== 4'b1000) begin
      errors++; $display("FAIL %s setup_ctl got=%b exp=1000", tag,
                         {bus.psel, bus.penable, bus.cmd_ready, bus.rsp_valid});
    end
    checks++;
    if ({bus.paddr, bus.pwrite, bus.pwdata} !== {a, w, exp_pwdata}) begin
      errors++; $display("FAIL %s setup_fields got=%h/%b/%h exp=%h/%b/%h", tag,
                         bus.paddr, bus.pwrite, bus.pwdata, a, w, exp_pwdata);
    end
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      bus.pready = (i == waits);
      bus.prdata = (i == waits && !bus.pwrite) ? slave_mem[bus.paddr] : DW'($urandom);
      #1;
      checks++;
      if ({bus.psel, bus.penable, bus.cmd_ready, bus.rsp_valid} !== {2'b11, (i == waits), 1'b0}) begin
        errors++; $display("FAIL %s access_ctl cyc=%0d got=%b exp=%b", tag, i,
                           {bus.psel, bus.penable, bus.cmd_ready, bus.rsp_valid},
                           {2'b11, (i == waits), 1'b0});
      end
      checks++;
      if ({bus.paddr, bus.pwrite, bus.pwdata} !== {a, w, exp_pwdata}) begin
        errors++; $display("FAIL %s access_fields cyc=%0d got=%h/%b/%h exp=%h/%b/%h", tag, i,
                           bus.paddr, bus.pwrite, bus.pwdata, a, w, exp_pwdata);
      end
      if (i == waits && bus.pwrite) slave_mem[bus.paddr] = bus.pwdata;
    end
    exp.rdata   = w ? '0 : ref_mem[a];
    exp.timeout = 1'b0;
    if (w) ref_mem[a] = d;
    @(negedge clk);
    bus.pready = 1'b0;
    #1;
    checks++;
    if ({bus.rsp_valid, bus.rsp_timeout, bus.rsp_rdata, bus.psel} !== {1'b1, exp.timeout, exp.rdata, 1'b0}) begin
      errors++; $display("FAIL %s response got=v%b t%b d%h psel%b exp=v1 t%b d%h psel0", tag,
                         bus.rsp_valid, bus.rsp_timeout, bus.rsp_rdata, bus.psel,
                         exp.timeout, exp.rdata);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL %s rsp_pulse got=%b exp=0", tag, bus.rsp_valid);
    end
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 3'h7;
    bus.cmd_wdata = 8'hFF;
    bus.pready    = 1'b0;
    bus.prdata    = '0;
    reset_n       = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata,
         bus.rsp_valid, bus.rsp_timeout, bus.rsp_rdata} !== '0) begin
      errors++; $display("FAIL reset_outputs got=%b%b%b %h %h %b%b %h exp=all zero",
                         bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata,
                         bus.rsp_valid, bus.rsp_timeout, bus.rsp_rdata);
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got=%b exp=1", bus.cmd_ready);
    end
    bus.cmd_valid = 1'b0;
    reset_n       = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.psel, bus.rsp_valid} !== 2'b00) begin
      errors++; $display("FAIL reset_release got=%b exp=00", {bus.psel, bus.rsp_valid});
    end
  endtask

  // Two writes with cmd_valid held; the second waits while the first stalls.
  task automatic test_back_to_back(input int wa);
    logic [AW-1:0] a1, a2;
    logic [DW-1:0] d1, d2;
    a1 = AW'($urandom); a2 = AW'($urandom);
    d1 = DW'($urandom); d2 = DW'($urandom);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = a1; bus.cmd_wdata = d1;
    @(negedge clk);
    bus.cmd_addr = a2; bus.cmd_wdata = d2;
    #1;
    checks++;
    if ({bus.psel, bus.penable, bus.cmd_ready, bus.paddr, bus.pwdata} !== {3'b100, a1, d1}) begin
      errors++; $display("FAIL b2b setup_a got=%b%b%b %h %h exp=100 %h %h",
                         bus.psel, bus.penable, bus.cmd_ready, bus.paddr, bus.pwdata, a1, d1);
    end
    for (int i = 0; i <= wa; i++) begin
      @(negedge clk);
      bus.pready = (i == wa);
      #1;
      checks++;
      if ({bus.psel, bus.penable, bus.cmd_ready, bus.paddr, bus.pwdata} !== {2'b11, (i == wa), a1, d1}) begin
        errors++; $display("FAIL b2b access_a cyc=%0d got=%b%b%b %h %h exp=11%b %h %h", i,
                           bus.psel, bus.penable, bus.cmd_ready, bus.paddr, bus.pwdata, (i == wa), a1, d1);
      end
      if (i == wa) slave_mem[bus.paddr] = bus.pwdata;
    end
    ref_mem[a1] = d1;
    @(negedge clk);
    bus.cmd_valid = 1'b0; bus.pready = 1'b0;
    #1;
    checks++;
    if ({bus.psel, bus.penable, bus.paddr, bus.pwdata, bus.rsp_valid, bus.rsp_rdata} !==
        {2'b10, a2, d2, 1'b1, 8'h00}) begin
      errors++; $display("FAIL b2b setup_b got=%b%b %h %h v%b %h exp=10 %h %h v1 00",
                         bus.psel, bus.penable, bus.paddr, bus.pwdata, bus.rsp_valid, bus.rsp_rdata, a2, d2);
    end
    @(negedge clk);
    bus.pready = 1'b1;
    #1;
    checks++;
    if ({bus.psel, bus.penable, bus.rsp_valid} !== 3'b110) begin
      errors++; $display("FAIL b2b access_b got=%b exp=110", {bus.psel, bus.penable, bus.rsp_valid});
    end
    slave_mem[bus.paddr] = bus.pwdata;
    ref_mem[a2] = d2;
    @(negedge clk);
    bus.pready = 1'b0;
    #1;
    checks++;
    if ({bus.rsp_valid, bus.rsp_timeout, bus.psel} !== 3'b100) begin
      errors++; $display("FAIL b2b resp_b got=%b exp=100", {bus.rsp_valid, bus.rsp_timeout, bus.psel});
    end
    @(negedge clk);
    xfer(1'b0, a1, 8'h00, 0, "b2b_readback_a");
    xfer(1'b0, a2, 8'h00, 0, "b2b_readback_b");
  endtask

  task automatic test_reset_mid();
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 3'h6;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    bus.pready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.psel, bus.penable, bus.rsp_valid, bus.paddr} !== {3'b000, 3'h0}) begin
      errors++; $display("FAIL reset_mid async got=%b%b%b %h exp=000 0",
                         bus.psel, bus.penable, bus.rsp_valid, bus.paddr);
    end
    bus.pready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset_n    = 1'b1;
    bus.pready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.cmd_ready, bus.psel, bus.rsp_valid} !== 3'b100) begin
        errors++; $display("FAIL reset_mid idle cyc=%0d got=%b exp=100", i,
                           {bus.cmd_ready, bus.psel, bus.rsp_valid});
      end
    end
    xfer(1'b0, 3'h6, 8'h00, 1, "after_reset_read");
  endtask

`ifdef APB_MASTER_TIMEOUT_EN
  task automatic test_stall();
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 3'h1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      bus.pready = 1'b0;
      #1;
      checks++;
      if ({bus.psel, bus.penable, bus.cmd_ready, bus.rsp_valid} !== 4'b1100) begin
        errors++; $display("FAIL timeout_wait cyc=%0d got=%b exp=1100", i,
                           {bus.psel, bus.penable, bus.cmd_ready, bus.rsp_valid});
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bus.rsp_valid, bus.rsp_timeout, bus.rsp_rdata, bus.psel} !== {2'b11, 8'h00, 1'b0}) begin
      errors++; $display("FAIL timeout_rsp got=v%b t%b d%h psel%b exp=v1 t1 d00 psel0",
                         bus.rsp_valid, bus.rsp_timeout, bus.rsp_rdata, bus.psel);
    end
    @(negedge clk);
    xfer(1'b0, 3'h1, 8'h00, TO - 1, "pready_on_expiry");
  endtask
`else
  task automatic test_stall();
    xfer(1'b0, 3'h1, 8'h00, 40, "long_stall_read");
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      xfer(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
           $urandom_range(0, 5), $sformatf("rand%0d", n));
    end
    for (int n = 0; n < 4; n++) test_back_to_back($urandom_range(0, 3));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      ref_mem[i]   = DW'(i * 8'h29 + 8'h11);
      slave_mem[i] = DW'(i * 8'h29 + 8'h11);
    end
    ref_mem[5]   = 8'h3C;
    slave_mem[5] = 8'h3C;
    test_reset();
    xfer(1'b1, 3'h2, 8'hA5, 0, "write_a5");
    xfer(1'b0, 3'h5, 8'h00, 4, "read_wait4");
    xfer(1'b0, 3'h2, 8'h00, 0, "readback_a5");
    test_back_to_back(0);
    test_back_to_back(2);
    test_stall();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_W, default 3, APB address width.
REQ-002 Parameter DATA_W, default 8, APB data width.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, maximum ACCESS-phase wait cycles; used only when the timeout feature is compiled in.
REQ-004 One clock and one reset: clk_i is the single clock; reset_n is asynchronous, active-low.
REQ-005 clk_i  input  1  clock; all state updates on rising edge.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 cmd_valid  input  1  command request.
REQ-008 cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-009 cmd_write  input  1  1=write, 0=read.
REQ-010 cmd_addr  input  ADDR_W  target address.
REQ-011 cmd_wdata  input  DATA_W  write data.
REQ-012 psel, penable, pwrite  output  1 each  APB control.
REQ-013 paddr  output  ADDR_W; pwdata  output  DATA_W.
REQ-014 prdata  input  DATA_W; pready  input  1  APB responder signals.
REQ-015 rsp_valid  output  1  one-cycle completion pulse; rsp_rdata  output  DATA_W; rsp_timeout  output  1.

Function
REQ-016 FSM states IDLE, SETUP, ACCESS; reset state IDLE.
REQ-017 cmd_ready SHALL be high in IDLE, and in ACCESS on the cycle pready is high; low otherwise (combinational from state and pready).
REQ-018 On cmd_valid&&cmd_ready, command fields are registered onto paddr/pwrite/pwdata and the FSM enters SETUP next cycle.
REQ-019 SETUP: psel=1, penable=0, lasts exactly one cycle, then ACCESS.
REQ-020 ACCESS: psel=1, penable=1; paddr/pwrite/pwdata held stable until pready sampled high.
REQ-021 ACCESS with pready=1: transfer completes; next state SETUP if a command is accepted that same cycle (back-to-back, psel stays high), else IDLE with psel=penable=0.
REQ-022 On completion, rsp_valid=1 for exactly one cycle following the pready edge; rsp_rdata=prdata captured at that edge for reads, 0 for writes; rsp_timeout=0.
REQ-023 pwdata SHALL be 0 during read transfers.
REQ-024 No response backpressure; consumer must accept every rsp_valid pulse.
REQ-025 Minimum transfer latency: command accept to rsp_valid = 3 cycles with zero wait states.

Reset
REQ-026 While reset_n=0: state IDLE, psel=penable=pwrite=0, paddr=pwdata=0, rsp_valid=rsp_timeout=0, rsp_rdata=0, timeout counter 0.
REQ-027 Reset asserted mid-transfer aborts immediately, psel drops asynchronously, no response issued.

Configuration
REQ-028 Macro APB_MASTER_TIMEOUT_EN: when defined, a counter counts ACCESS cycles with pready=0; on reaching TIMEOUT_CYCLES the transfer aborts to IDLE, rsp_valid=1 with rsp_timeout=1 and rsp_rdata=0.
REQ-029 Counter clears on every entry to SETUP; pready high on the expiry cycle wins (normal completion).
REQ-030 Without the macro, ACCESS waits indefinitely and rsp_timeout is tied to 0.

Structure
REQ-031 Package apb_master_pkg holds the state enum (IDLE/SETUP/ACCESS), default ADDR_W/DATA_W constants and a response struct (rdata, timeout).
REQ-032 Sub-module apb_master_wdog (timeout counter, start/clear in, expired out), instantiated only under APB_MASTER_TIMEOUT_EN.

Verification
REQ-033 Write addr=3'h2 data=8'hA5, pready=1 -> SETUP 1 cycle, ACCESS 1 cycle, pwdata=8'hA5, rsp_valid at cycle 3, rsp_rdata=0.
REQ-034 Read addr=3'h5, pready low 4 cycles then high with prdata=8'h3C -> paddr held 5 cycles, rsp_rdata=8'h3C.
REQ-035 Two queued writes (cmd_valid held) -> second SETUP immediately after first ACCESS, psel never drops.
REQ-036 Reset pulse during ACCESS -> psel/penable 0 asynchronously, no rsp_valid, FSM IDLE after release.
REQ-037 With APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, pready stuck 0 -> abort after 16 ACCESS cycles, rsp_timeout=1.
REQ-038 cmd_valid held while busy -> cmd_ready low in SETUP and in stalled ACCESS; command fields unchanged on bus.
